// File: rtl/dividend_rebuilder.sv
// dividend_rebuilder: multi-cycle shift-add recombiner, product = quotient * divisor + remainder
//   Ports:
//     clk, rst              clock, synchronous active-high reset
//     in_valid / in_ready   operand handshake (quotient, divisor, remainder)
//     out_valid / out_ready result handshake (product, bad_in)
//     bad_in                operands had divisor == 0 or remainder >= divisor
//   Option macro DIVIDEND_REBUILDER_EARLY_EXIT_EN: leave BUSY once the multiplier has no set bits left.
module dividend_rebuilder #(
    parameter int QW = 40,
    parameter int DW = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [QW-1:0]    quotient,
    input  logic [DW-1:0]    divisor,
    input  logic [DW-1:0]    remainder,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [QW+DW-1:0] product,
    output logic             bad_in
);
    localparam int PW = QW + DW;
    localparam int CW = $clog2(QW) + 1;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t        state;
    logic [PW-1:0] acc, mcand, acc_nx;
    logic [QW-1:0] mplier;
    logic [CW-1:0] cnt;
    logic          last;
    always_comb begin
        acc_nx = mplier[0] ? acc + mcand : acc;
`ifdef DIVIDEND_REBUILDER_EARLY_EXIT_EN
        // post-shift multiplier empty: no further partial products can contribute
        last = (cnt == CW'(QW - 1)) || (mplier[QW-1:1] == '0);
`else
        last = cnt == CW'(QW - 1);
`endif
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            product   <= '0;
            bad_in    <= 1'b0;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    acc      <= PW'(remainder);
                    mcand    <= PW'(divisor);
                    mplier   <= quotient;
                    cnt      <= '0;
                    bad_in   <= (divisor == '0) || (remainder >= divisor);
                    state    <= BUSY;
                    in_ready <= 1'b0;
                end
                BUSY: begin
                    acc    <= acc_nx;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CW'(1);
                    if (last) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        product   <= acc_nx;
                    end
                end
                DONE: if (out_ready) begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dividend_rebuilder.sv
// tb_dividend_rebuilder: vector table, corner sequences and random ops against q*d+r arithmetic
module tb_dividend_rebuilder;
    localparam int QW = 40;
    localparam int DW = 32;
    logic            clk = 0, rst = 1, in_valid = 0, out_ready = 0;
    logic            in_ready, out_valid, bad_in;
    logic [QW-1:0]   quotient = '0;
    logic [DW-1:0]   divisor = '0, remainder = '0;
    logic [QW+DW-1:0] product;
    int n_tests = 0, n_fail = 0;
    typedef struct {
        logic [QW-1:0]    q;
        logic [DW-1:0]    d;
        logic [DW-1:0]    r;
        logic [QW+DW-1:0] p;
        logic             bad;
    } vec_t;
    vec_t tv[6];
    dividend_rebuilder #(.QW(QW), .DW(DW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .quotient(quotient), .divisor(divisor), .remainder(remainder),
        .out_valid(out_valid), .out_ready(out_ready), .product(product), .bad_in(bad_in)
    );
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    function automatic int exp_lat(input logic [QW-1:0] q);
`ifdef DIVIDEND_REBUILDER_EARLY_EXIT_EN
        int n = 1;
        for (int i = 0; i < QW; i++) if (q[i]) n = i + 1;
        return n;
`else
        return QW;
`endif
    endfunction
    task automatic send(input logic [QW-1:0] q, input logic [DW-1:0] d, input logic [DW-1:0] r);
        int t = 0;
        while (!in_ready && t < 100) begin @(negedge clk); t++; end
        chk("in_ready_wait", in_ready, 1);
        in_valid = 1; quotient = q; divisor = d; remainder = r;
        @(negedge clk);
        in_valid = 0;
    endtask
    task automatic run_op(input logic [QW-1:0] q, input logic [DW-1:0] d, input logic [DW-1:0] r,
                          input bit bp, output logic [QW+DW-1:0] p, output logic b, output int lat);
        send(q, d, r);
        lat = 0;
        while (!out_valid && lat < 100) begin
            if (bp) out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            lat++;
        end
        p = product;
        b = bad_in;
        if (bp) repeat ($urandom_range(0, 3)) begin out_ready = 0; @(negedge clk); end
        out_ready = 1;
        @(negedge clk);
    endtask
    initial begin
        logic [QW+DW-1:0] p, ep;
        logic b;
        int lat;
        tv[0] = '{40'd5, 32'd5, 32'd4, 72'd29, 1'b0};
        tv[1] = '{40'hFF_FFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 72'hFF_FFFF_FEFF_FFFF_FFFF, 1'b0};
        tv[2] = '{40'd7, 32'd0, 32'd3, 72'd3, 1'b1};
        tv[3] = '{40'd1, 32'd5, 32'd5, 72'd10, 1'b1};
        tv[4] = '{40'd3, 32'd9, 32'd1, 72'd28, 1'b0};
        tv[5] = '{40'd0, 32'd7, 32'd6, 72'd6, 1'b0};
        repeat (3) @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_product", product, 0);
        chk("rst_bad_in", bad_in, 0);
        rst = 0;
        out_ready = 1;
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            run_op(tv[i].q, tv[i].d, tv[i].r, 0, p, b, lat);
            chk($sformatf("vec%0d_product", i), p, tv[i].p);
            chk($sformatf("vec%0d_bad_in", i), b, tv[i].bad);
            chk($sformatf("vec%0d_latency", i), lat, exp_lat(tv[i].q));
        end
        out_ready = 0;
        send(40'd5, 32'd5, 32'd4);
        lat = 0;
        while (!out_valid && lat < 100) begin @(negedge clk); lat++; end
        chk("bp_latency", lat, exp_lat(40'd5));
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'(i & 1);
            quotient = {8'd0, $urandom}; divisor = $urandom; remainder = $urandom;
            @(negedge clk);
            chk("bp_out_valid", out_valid, 1);
            chk("bp_product", product, 29);
            chk("bp_in_ready", in_ready, 0);
        end
        in_valid = 1;
        out_ready = 1;
        @(negedge clk);
        chk("bp_release_out_valid", out_valid, 0);
        chk("bp_release_in_ready", in_ready, 1);
        in_valid = 0;
        @(negedge clk);
        chk("bp_no_turnaround_accept", in_ready, 1);
        send(40'hAB_CDEF_1234, 32'd1000, 32'd7);
        repeat (17) @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_product", product, 0);
        run_op(40'd3, 32'd9, 32'd1, 0, p, b, lat);
        chk("midrst_fresh_product", p, 28);
        for (int i = 0; i < 1000; i++) begin
            logic [QW-1:0] q;
            logic [DW-1:0] d, r;
            q = QW'({$urandom, $urandom} >> $urandom_range(24, 64));
            d = ($urandom_range(0, 15) == 0) ? '0 : $urandom >> $urandom_range(0, 31);
            r = $urandom >> $urandom_range(0, 31);
            run_op(q, d, r, 1, p, b, lat);
            ep = (QW+DW)'(q) * (QW+DW)'(d) + (QW+DW)'(r);
            chk("rand_product", p, ep);
            chk("rand_bad_in", b, (d == 0) || (r >= d));
            chk("rand_latency", lat, exp_lat(q));
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
